// File: rtl/pr_axi_reader.sv
// Read-stream engine: turns a (byte address, word count) request into 512-bit AXI
// read bursts and unpacks the returned beats into a 64-bit valid/ready word stream.
module pr_axi_reader #(
  parameter logic [15:0] ID        = 16'd0,
  parameter int          MAX_BURST = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [63:0]  req_addr,
  input  logic [31:0]  req_count,
  output logic [15:0]  arid_m,
  output logic [63:0]  araddr_m,
  output logic [7:0]   arlen_m,
  output logic [2:0]   arsize_m,
  output logic         arvalid_m,
  input  logic         arready_m,
  input  logic [15:0]  rid_m,
  input  logic [511:0] rdata_m,
  input  logic [1:0]   rresp_m,
  input  logic         rlast_m,
  input  logic         rvalid_m,
  output logic         rready_m,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  out_data,
  output logic         out_last,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  localparam logic [32:0] MAX_B = 33'(MAX_BURST);

  state_t        state_q, state_d;
  logic [57:0]   line_q, line_d;
  logic [32:0]   lines_left_q, lines_left_d;
  logic [31:0]   words_left_q, words_left_d;
  logic [511:0]  buf_q, buf_d;
  logic          buf_valid_q, buf_valid_d;
  logic [2:0]    idx_q, idx_d;
  logic [2:0]    off_q, off_d;
  logic          first_q, first_d;
  logic          err_q, err_d;

  logic [32:0]   page_room;
  logic [32:0]   burst_len;
  logic [63:0]   beat_words [8];
  logic          buf_last;
  logic          out_fire;
  logic          r_fire;
  logic          unused_ok;

  assign unused_ok = ^{rid_m, req_addr[2:0]};

  for (genvar gi = 0; gi < 8; gi++) begin : g_unpack
    assign beat_words[gi] = buf_q[64*gi +: 64];
  end

  // Burst length is clipped by remaining lines, MAX_BURST and the 4 KB page end.
  always_comb begin
    page_room = 33'd64 - {27'd0, line_q[5:0]};
    burst_len = lines_left_q;
    if (burst_len > MAX_B) burst_len = MAX_B;
    if (burst_len > page_room) burst_len = page_room;
  end

  assign buf_last  = (idx_q == 3'd7) || (words_left_q == 32'd1);
  assign out_fire  = buf_valid_q && out_ready;
  assign rready_m  = (state_q == S_R) && (!buf_valid_q || (buf_last && out_ready));
  assign r_fire    = rvalid_m && rready_m;

  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign arid_m    = ID;
  assign arsize_m  = 3'd6;
  assign arvalid_m = (state_q == S_AR);
  assign araddr_m  = arvalid_m ? {line_q, 6'b0} : 64'd0;
  assign arlen_m   = arvalid_m ? (burst_len[7:0] - 8'd1) : 8'd0;
  assign out_valid = buf_valid_q;
  assign out_data  = buf_valid_q ? beat_words[idx_q] : 64'd0;
  assign out_last  = buf_valid_q && (words_left_q == 32'd1);

  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    lines_left_d = lines_left_q;
    words_left_d = words_left_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    idx_d        = idx_q;
    off_d        = off_q;
    first_d      = first_q;
    err_d        = err_q;

    if (out_fire) begin
      words_left_d = words_left_q - 32'd1;
      if (buf_last) buf_valid_d = 1'b0;
      else          idx_d       = idx_q + 3'd1;
    end
    // A new beat may land in the same cycle the old buffer's last word leaves.
    if (r_fire) begin
      buf_d       = rdata_m;
      buf_valid_d = 1'b1;
      idx_d       = first_q ? off_q : 3'd0;
      first_d     = 1'b0;
      if (rresp_m != 2'd0) err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          line_d       = req_addr[63:6];
          off_d        = req_addr[5:3];
          words_left_d = req_count;
          lines_left_d = ({30'd0, req_addr[5:3]} + {1'b0, req_count} + 33'd7) >> 3;
          first_d      = 1'b1;
          err_d        = 1'b0;
          buf_valid_d  = 1'b0;
          state_d      = (req_count == 32'd0) ? S_DONE : S_AR;
        end
      end
      S_AR: begin
        if (arready_m) begin
          line_d       = line_q + {25'd0, burst_len};
          lines_left_d = lines_left_q - burst_len;
          state_d      = S_R;
        end
      end
      S_R: begin
        if (r_fire && rlast_m && (lines_left_q != 33'd0)) state_d = S_AR;
        if (out_fire && (words_left_q == 32'd1))          state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      line_q       <= '0;
      lines_left_q <= '0;
      words_left_q <= '0;
      buf_valid_q  <= 1'b0;
      idx_q        <= '0;
      off_q        <= '0;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      lines_left_q <= lines_left_d;
      words_left_q <= words_left_d;
      buf_valid_q  <= buf_valid_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      first_q      <= first_d;
      err_q        <= err_d;
    end
  end

  // Beat data needs no reset; out_data is masked by buf_valid.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_pr_axi_reader.sv
// Scoreboard bench for pr_axi_reader: directed requests against a zero-latency AXI
// memory model; expected words and bursts are queued at issue and checked by a monitor.
`timescale 1ns/1ps
module tb_pr_axi_reader;

  localparam logic [15:0] TB_ID = 16'h00A5;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready;
  logic [63:0]  req_addr;
  logic [31:0]  req_count;
  logic [15:0]  arid_m;
  logic [63:0]  araddr_m;
  logic [7:0]   arlen_m;
  logic [2:0]   arsize_m;
  logic         arvalid_m, arready_m;
  logic [15:0]  rid_m;
  logic [511:0] rdata_m;
  logic [1:0]   rresp_m;
  logic         rlast_m, rvalid_m, rready_m;
  logic         out_valid, out_ready, out_last, done, err;
  logic [63:0]  out_data;

  always #5 clk = ~clk;

  pr_axi_reader #(.ID(TB_ID), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_count(req_count),
    .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
    .arvalid_m(arvalid_m), .arready_m(arready_m),
    .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .err(err)
  );

  typedef struct { logic [63:0] data; logic last; } word_t;
  typedef struct { logic [63:0] addr; logic [7:0] len; } ar_t;
  word_t exp_q[$];
  ar_t   ar_q[$];

  int n_vec = 0, n_fail = 0;
  int cyc = 0;
  int bp_en = 0, inj_burst = -1, ar_cnt = 0;
  int hs_cnt = 0, last_hs_cyc = 0, done_cnt = 0, exp_done = 0;

  logic        mem_busy = 1'b0, mem_chk_err = 1'b0;
  logic [57:0] mem_line = '0;
  logic [7:0]  mem_len = '0, mem_beat = '0;
  logic        prev_stall = 1'b0, prev_ar_stall = 1'b0;
  logic [63:0] prev_data = '0, prev_ara = '0;
  logic [7:0]  prev_arl = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(input logic [63:0] w);
    logic [31:0] lo;
    lo = w[31:0];
    return {lo ^ 32'h5A5A_F00D, lo};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"},
          {req_ready, arvalid_m, arsize_m, arid_m, rready_m, out_valid, out_last, done, err, arlen_m},
          {1'b1, 1'b0, 3'd6, TB_ID, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    check({name, "_araddr"}, araddr_m, 64'd0);
    check({name, "_out_data"}, out_data, 64'd0);
  endtask

  task automatic push_words(input logic [63:0] first_w, input int count);
    for (int i = 0; i < count; i++) begin
      word_t e;
      e.data = mem_word(first_w + 64'(i));
      e.last = (i == count - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_ar(input logic [63:0] a, input logic [7:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      ar_t e;
      e.addr = a + 64'(i) * ({56'd0, l} + 64'd1) * 64'd64;
      e.len  = l;
      ar_q.push_back(e);
    end
  endtask

  // Presents a request and returns after the cycle following acceptance.
  task automatic issue(input logic [63:0] a, input logic [31:0] c, input int hold, output int acc);
    int t;
    @(posedge clk); #1;
    req_addr = a; req_count = c; req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 100) begin @(negedge clk); t++; end
    if (!req_ready) check("accept_timeout", req_ready, 1);
    acc = cyc;
    @(posedge clk); #1;
    if (hold == 0) req_valid = 1'b0;
    @(negedge clk);
    check("arvalid_after_accept", arvalid_m, (c != 0));
    check("err_cleared_on_accept", err, 0);
    if (c == 0) check("done_after_count0", done, 1);
  endtask

  task automatic run_req(input logic [63:0] a, input logic [31:0] c, input int hold, input logic exp_err);
    int acc, t, dc;
    issue(a, c, hold, acc);
    t = 0;
    while (!done && t < 20000) begin
      @(posedge clk); #1;
      if (cyc > acc + hold) req_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    dc = cyc;
    if (!done) check("done_timeout", done, 1);
    else if (c != 0) check("done_timing", dc, last_hs_cyc + 1);
    check("err_at_done", err, exp_err);
    check("words_outstanding", exp_q.size(), 0);
    check("bursts_outstanding", ar_q.size(), 0);
    exp_done++;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_done", {req_ready, done}, {1'b1, 1'b0});
    check("done_pulses", done_cnt, exp_done);
    $display("req addr=%0h count=%0d accepted@%0d done@%0d err=%0b", a, c, acc, dc, err);
  endtask

  // Output backpressure driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (bp_en != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Zero-latency AXI memory: one burst at a time, beats on consecutive cycles.
  initial begin
    logic ar_f, r_f, rst_s;
    logic [63:0] ar_a;
    logic [7:0]  ar_l;
    arready_m = 1'b0; rvalid_m = 1'b0; rdata_m = '0; rresp_m = 2'd0; rlast_m = 1'b0; rid_m = TB_ID;
    forever begin
      @(negedge clk);
      if (mem_chk_err) begin
        check("err_after_bad_beat", err, 1);
        mem_chk_err = 1'b0;
      end
      ar_f = arvalid_m && arready_m;
      r_f  = rvalid_m && rready_m;
      ar_a = araddr_m; ar_l = arlen_m; rst_s = rst;
      if (r_f && rresp_m != 2'd0 && !rst_s) mem_chk_err = 1'b1;
      @(posedge clk); #1;
      if (rst_s) begin
        mem_busy = 1'b0;
      end else begin
        if (r_f) begin
          if (mem_beat == mem_len) mem_busy = 1'b0;
          else begin mem_beat++; mem_line++; end
        end
        if (ar_f) begin
          mem_busy = 1'b1; mem_line = ar_a[63:6]; mem_len = ar_l; mem_beat = '0; ar_cnt++;
        end
      end
      arready_m = !mem_busy && ((bp_en != 0) ? 1'($urandom_range(0, 1)) : 1'b1);
      rvalid_m  = mem_busy;
      for (int k = 0; k < 8; k++) rdata_m[64*k +: 64] = mem_word(64'({mem_line, 3'(k)}));
      rlast_m = mem_busy && (mem_beat == mem_len);
      rresp_m = (mem_busy && ar_cnt == inj_burst && mem_beat == 8'd4) ? 2'd2 : 2'd0;
    end
  end

  // Monitor: pops the scoreboard on every output word and AR handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0; prev_ar_stall = 1'b0;
        continue;
      end
      if (done) done_cnt++;
      if (prev_stall) check("out_hold", {out_valid, out_data}, {1'b1, prev_data});
      if (prev_ar_stall) check("ar_hold", {arvalid_m, araddr_m, arlen_m}, {1'b1, prev_ara, prev_arl});
      if (out_valid && rready_m) check("rready_with_pending_words", out_ready, 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("word_unexpected", out_valid, 0);
        else begin
          word_t e;
          e = exp_q.pop_front();
          check("word_data", out_data, e.data);
          check("word_last", out_last, e.last);
        end
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (arvalid_m && arready_m) begin
        if (ar_q.size() == 0) check("ar_unexpected", arvalid_m, 0);
        else begin
          ar_t e;
          e = ar_q.pop_front();
          check("ar_beat", {araddr_m, arlen_m, arsize_m, arid_m}, {e.addr, e.len, 3'd6, TB_ID});
        end
      end
      prev_stall    = out_valid && !out_ready;
      prev_data     = out_data;
      prev_ar_stall = arvalid_m && !arready_m;
      prev_ara      = araddr_m;
      prev_arl      = arlen_m;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, base, t;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Aligned 1001 words: 7 full bursts then a 14-beat tail.
    push_ar(64'd0, 8'd15, 7); push_ar(64'd7168, 8'd13, 1); push_words(64'd0, 1001);
    run_req(64'd0, 32'd1001, 0, 1'b0);

    // Line 376, offset 1: page-limited first burst.
    push_ar(64'd24064, 8'd7, 1); push_ar(64'd24576, 8'd15, 7); push_ar(64'd31744, 8'd5, 1);
    push_words(64'd3009, 1001);
    run_req(64'd24072, 32'd1001, 0, 1'b0);

    // Zero-length request: no AXI traffic, done next cycle.
    run_req(64'h1238, 32'd0, 0, 1'b0);

    // Short request with req_valid held high while busy.
    push_ar(64'd0, 8'd0, 1); push_words(64'd1, 3);
    run_req(64'd8, 32'd3, 4, 1'b0);

    // Random backpressure on both out_ready and arready.
    bp_en = 1;
    push_ar(64'd0, 8'd15, 7); push_ar(64'd7168, 8'd13, 1); push_words(64'd0, 1001);
    run_req(64'd0, 32'd1001, 0, 1'b0);
    bp_en = 0;

    // Error response on beat 5 of burst 2.
    inj_burst = ar_cnt + 2;
    push_ar(64'd0, 8'd15, 1); push_ar(64'd1024, 8'd8, 1); push_words(64'd0, 200);
    run_req(64'd0, 32'd200, 0, 1'b1);
    inj_burst = -1;

    // Next request clears err on acceptance.
    push_ar(64'd0, 8'd0, 1); push_words(64'd1, 3);
    run_req(64'd8, 32'd3, 0, 1'b0);

    // Reset pulsed in the middle of a long request.
    push_ar(64'd0, 8'd15, 7); push_ar(64'd7168, 8'd13, 1); push_words(64'd0, 1001);
    base = hs_cnt;
    issue(64'd0, 32'd1001, 0, acc);
    t = 0;
    while (hs_cnt < base + 50 && t < 5000) begin @(negedge clk); t++; end
    check("midburst_progress", (hs_cnt >= base + 50), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midburst_reset");
    rst = 1'b0;
    exp_q.delete(); ar_q.delete();
    $display("req addr=0 count=1001 accepted@%0d reset after %0d words", acc, hs_cnt - base);

    // Recovery after reset.
    push_ar(64'd0, 8'd0, 1); push_words(64'd1, 3);
    run_req(64'd8, 32'd3, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pr_axi_reader.md
# pr_axi_reader

Read-stream engine between the AXI memory port (`axi_emu` in simulation, the shell DDR port on hardware) and the PageRank core's consumers. It takes a request for N consecutive 64-bit words starting at any 8-byte-aligned byte address, issues 512-bit AXI read bursts on the AR/R channels, and unpacks each returned beat into a 64-bit valid/ready word stream. The core uses one instance per array stream: vertices at `VADDR`, in-edges at `IEADDR`, and ranks.

## Interface
- `ID`, 16'd0: value driven on `arid_m`.
- `MAX_BURST`, 16: maximum beats per burst, power of two in the range 1..64.
- `clk` input 1: clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request strobe.
- `req_ready` output 1: high only in IDLE.
- `req_addr` input 64: byte address; bits [2:0] are ignored (treated as 0).
- `req_count` input 32: number of 64-bit words to read.
- `arid_m` output 16: constant `ID`.
- `araddr_m` output 64: 64-byte-aligned burst address.
- `arlen_m` output 8: beats minus 1.
- `arsize_m` output 3: constant 3'd6.
- `arvalid_m` output 1, `arready_m` input 1: AR handshake.
- `rid_m` input 16: ignored.
- `rdata_m` input 512: read beat.
- `rresp_m` input 2: read response.
- `rlast_m` input 1: last beat of the burst.
- `rvalid_m` input 1, `rready_m` output 1: R handshake.
- `out_valid` output 1, `out_ready` input 1, `out_data` output 64: word stream.
- `out_last` output 1: high with the final word of the request.
- `done` output 1: one-cycle pulse when the request completes.
- `err` output 1: sticky; cleared by reset or by a new request being accepted.

## Operation
- Acceptance: when `req_valid && req_ready`, latch the following:
  - line = addr[63:6];
  - off = addr[5:3];
  - words_left = count;
  - lines_left = ceil((off + count)/8), computed at 33-bit width.
- States:
  - IDLE.
  - AR:
    - Drive `arvalid_m` and hold its value stable until `arready_m`.
    - Burst beats b = min(lines_left, MAX_BURST, 64 - line[5:0]); bursts never cross a 4 KB page.
    - `arlen_m` = b-1; `araddr_m` = {line, 6'b0}.
  - R:
    - Exactly one burst is outstanding.
    - On the AR handshake, add b to line and subtract b from lines_left.
  - DONE: for one cycle, then return to IDLE.
- Transitions:
  - IDLE goes to AR when a request with count>0 is accepted.
  - IDLE goes to DONE when a request with count=0 is accepted; no AXI traffic is issued.
  - AR goes to R on the AR handshake.
  - R goes to AR on the rlast beat when lines_left>0.
  - R goes to DONE after the final word handshake on `out`.
- Unpack buffer: one 512-bit register plus a valid flag and a 3-bit word index.
  - `rready_m` = !buf_valid, or (buf_valid and the current word is the final word of the buffer and `out_ready`). This allows back-to-back beats.
  - Word k of a beat is rdata[64k+63:64k].
  - First beat of the request: the index starts at off.
  - Every beat: emit words until index 7, or until words_left reaches 0.
- Output:
  - `out_data` is the selected word.
  - `out_valid` = buf_valid.
  - `out_last` = (words_left==1).
  - words_left decrements on each `out` handshake.
- `rresp_m` != 0 on any accepted beat sets `err`. The data is still forwarded and the word count is unaffected.
- Reset applies anywhere, including mid-burst. The memory model is reset by the same `rst`, so no in-flight drain is required.

## Timing
- Reset values: `req_ready`=1 and `arsize_m`=6 (both are constants in IDLE); `arid_m`=`ID`; all other outputs are 0.
- `arvalid_m` rises the cycle after acceptance.
- `out_valid` rises the cycle after the first R handshake.
- With `out_ready`=1, throughput is 1 word/cycle within a burst. Between bursts there is a gap of at least 1 cycle (AR is re-issued after rlast).
- `done` is high in the cycle after the final `out` handshake. For count=0, it is high the cycle after acceptance.
- `req_ready` returns high in the cycle after `done`.
- A `req_valid` held high during a busy period is ignored until `req_ready` is high.

## Test plan
- Addr 0, count 1001, `MAX_BURST` 16, zero-latency memory:
  - Expect 8 bursts: arlen 15 ×7, then arlen 13.
  - Expect 1001 words equal to memory words 0..1000.
  - `out_last` is high on word 1000; one `done` pulse follows.
- Addr 24072 (line 376, off 1), count 1001:
  - First burst arlen 7 (page limit), then 15 ×7.
  - Last burst arlen 5 (126 lines total).
  - Expect 1001 words starting at memory word 3009.
- Count 0 at any address: no `arvalid_m`; `done` the cycle after acceptance; `out_valid` never rises.
- Addr 8, count 3: a single burst with arlen 0; out words 1,2,3; `out_last` on word 3.
- Random `out_ready` backpressure (50%) on the addr-0 case:
  - `out_data` stays stable while `out_valid && !out_ready`.
  - The word sequence is identical to the no-backpressure run.
  - `rready_m` is never high while the buffer holds unsent words, except when the last word is being accepted.
- `rresp_m`=2 on beat 5 of burst 2, followed by a new request:
  - `err` sets in the cycle after that beat and stays set through `done`.
  - `err` clears when the next request is accepted.
  - `rst` pulsed mid-burst returns all outputs to their reset values next cycle.
